// File: rtl/axis_i2s_tx.sv
// AXI-Stream to I2S transmitter: buffers one stereo pair and serialises it MSB first,
// generating LRCK/SCLK from a free-running frame counter (one frame = one pair).
module axis_i2s_tx #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DIV_LOG2   = 3,
    parameter int unsigned SLOT_LOG2  = 5
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  tx_mclk,
    output logic                  tx_lrck,
    output logic                  tx_sclk,
    output logic                  tx_sdout,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam int unsigned W  = DIV_LOG2 + SLOT_LOG2 + 1;
    localparam int unsigned IW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {StWaitL, StWaitR, StFull} state_e;

    state_e                state_q, state_d;
    logic [W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [DATA_WIDTH-1:0] sh_sel;
    logic [SLOT_LOG2-1:0]  bit_idx;
    logic                  sclk_q, sclk_d, lrck_q, lrck_d, sdout_q, sdout_d;
    logic                  underrun_q, underrun_d, frame_err_q, frame_err_d;
    logic                  accept, boundary;

    assign tx_mclk      = axis_clk;
    assign s_axis_ready = (state_q != StFull);
    assign accept       = s_axis_valid && s_axis_ready;
    assign boundary     = (cnt_q == '1);

    assign tx_sclk   = sclk_q;
    assign tx_lrck   = lrck_q;
    assign tx_sdout  = sdout_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

    // Serial clocks and data are derived from the post-edge counter value so the
    // registered outputs line up with cnt_q.
    always_comb begin
        cnt_d   = cnt_q + W'(1);
        sclk_d  = cnt_d[DIV_LOG2-1];
        lrck_d  = cnt_d[W-1];
        bit_idx = cnt_d[DIV_LOG2 +: SLOT_LOG2];
        sh_sel  = lrck_d ? sh_r_q : sh_l_q;
        sdout_d = sdout_q;
        if (cnt_q[DIV_LOG2-1:0] == '1) begin
            if (bit_idx != '0 && 32'(bit_idx) <= DATA_WIDTH) begin
                sdout_d = sh_sel[IW'(DATA_WIDTH - 32'(bit_idx))];
            end else begin
                sdout_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StWaitL: begin
                if (accept) begin
                    if (!s_axis_last) begin
                        hold_l_d = s_axis_data;
                        state_d  = StWaitR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StWaitR: begin
                if (accept) begin
                    if (s_axis_last) begin
                        hold_r_d = s_axis_data;
                        state_d  = StFull;
                    end else begin
                        hold_l_d    = s_axis_data;
                        frame_err_d = 1'b1;
                    end
                end
            end
            StFull: ;
            default: state_d = StWaitL;
        endcase

        // A pair completing on the boundary edge itself waits for the next frame.
        if (boundary) begin
            if (state_q == StFull) begin
                sh_l_d  = hold_l_q;
                sh_r_d  = hold_r_q;
                state_d = StWaitL;
            end else begin
                sh_l_d     = '0;
                sh_r_d     = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q     <= StWaitL;
            cnt_q       <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdout_q     <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            sclk_q      <= sclk_d;
            lrck_q      <= lrck_d;
            sdout_q     <= sdout_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Directed bench for axis_i2s_tx: frames are captured on SCLK rising and compared against
// hand-computed 32-bit slot words (b0 in the MSB).
module tb_axis_i2s_tx;

    logic        clk, rstn;
    logic [23:0] s_data;
    logic        s_valid, s_ready, s_last;
    logic        tx_mclk, tx_lrck, tx_sclk, tx_sdout, underrun, frame_err;

    logic [8:0]  cyc;
    int          checks, errors;
    int          ur_cnt, fe_cnt;

    axis_i2s_tx dut (
        .axis_clk    (clk),
        .axis_resetn (rstn),
        .s_axis_data (s_data),
        .s_axis_valid(s_valid),
        .s_axis_ready(s_ready),
        .s_axis_last (s_last),
        .tx_mclk     (tx_mclk),
        .tx_lrck     (tx_lrck),
        .tx_sclk     (tx_sclk),
        .tx_sdout    (tx_sdout),
        .underrun    (underrun),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame counter: expected value of the DUT counter after each edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= '0;
        else       cyc <= cyc + 9'd1;
    end

    always @(negedge clk) begin
        if (underrun === 1'b1)  ur_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input logic [8:0] v);
        int n = 0;
        while (cyc !== v && n < 600) begin
            step;
            n++;
        end
        checks++;
        if (cyc !== v) begin
            errors++;
            $display("FAIL wait_cnt: counter %0d, required %0d", cyc, v);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 1100) begin
            step;
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: ready %b, required 1", s_ready);
        end
        step;
        s_valid = 1'b0;
    endtask

    task automatic capture(output logic [31:0] lw, output logic [31:0] rw,
                           output int ur, output int clk_err);
        int u0;
        wait_cnt(9'd0);
        u0      = ur_cnt;
        lw      = '0;
        rw      = '0;
        clk_err = 0;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) step;
            if (tx_sclk !== cyc[2] || tx_lrck !== cyc[8]) clk_err++;
            if (cyc[2:0] == 3'd4) begin
                if (!cyc[8]) lw = {lw[30:0], tx_sdout};
                else         rw = {rw[30:0], tx_sdout};
            end
        end
        ur = ur_cnt - u0;
    endtask

    task automatic test_reset;
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_sclk, tx_lrck, tx_sdout, underrun, frame_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: sclk/lrck/sdout/ur/fe %b, required 00000",
                     {tx_sclk, tx_lrck, tx_sdout, underrun, frame_err});
        end
        checks++;
        if (tx_mclk !== 1'b1) begin
            errors++;
            $display("FAIL reset_mclk_high: mclk %b, required 1", tx_mclk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (tx_mclk !== 1'b0) begin
            errors++;
            $display("FAIL reset_mclk_low: mclk %b, required 0", tx_mclk);
        end
        rstn = 1'b1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready %b, required 1", s_ready);
        end
    endtask

    task automatic test_idle;
        logic [31:0] lw, rw;
        int ur, ce;
        step;
        capture(lw, rw, ur, ce);
        checks++;
        if (ce !== 0) begin
            errors++;
            $display("FAIL idle_clocks: %0d sclk/lrck errors, required 0", ce);
        end
        checks++;
        if (lw !== 32'h0 || rw !== 32'h0) begin
            errors++;
            $display("FAIL idle_sdout: L %h R %h, required 0 0", lw, rw);
        end
        checks++;
        if (ur !== 1) begin
            errors++;
            $display("FAIL idle_underrun: %0d pulses, required 1", ur);
        end
    endtask

    task automatic test_pair;
        logic [31:0] lw, rw;
        int ur, ce;
        wait_cnt(9'd100);
        send(24'h800001, 1'b0);
        send(24'h7FFFFE, 1'b1);
        capture(lw, rw, ur, ce);
        checks++;
        if (lw !== 32'h4000_0080) begin
            errors++;
            $display("FAIL pair_left: %h, required 40000080", lw);
        end
        checks++;
        if (rw !== 32'h3FFF_FF00) begin
            errors++;
            $display("FAIL pair_right: %h, required 3fffff00", rw);
        end
        checks++;
        if (ur !== 0 || ce !== 0) begin
            errors++;
            $display("FAIL pair_ur_clk: underrun %0d clkerr %0d, required 0 0", ur, ce);
        end
    endtask

    task automatic test_back_to_back;
        int beats = 0;
        logic acc;
        wait_cnt(9'd0);
        s_data  = 24'h000001;
        s_last  = 1'b0;
        s_valid = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            acc = s_valid && s_ready;
            step;
            if (acc) begin
                beats++;
                s_last = ~s_last;
                s_data = s_data + 24'd1;
            end
            if (cyc == 9'd511) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_low: ready %b at cnt 511, required 0", s_ready);
                end
            end
            if (cyc == 9'd0) begin
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_rise: ready %b at cnt 0, required 1", s_ready);
                end
            end
            if (i == 512) begin
                checks++;
                if (beats !== 2) begin
                    errors++;
                    $display("FAIL b2b_beats_frame: %0d beats, required 2", beats);
                end
            end
        end
        s_valid = 1'b0;
        checks++;
        if (beats !== 4) begin
            errors++;
            $display("FAIL b2b_beats_total: %0d beats, required 4", beats);
        end
    endtask

    task automatic test_frame_err;
        logic [31:0] lw, rw;
        int ur, ce, fe0;
        fe0 = fe_cnt;
        wait_cnt(9'd50);
        send(24'hABCDEF, 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_pulse: frame_err %b, required 1", frame_err);
        end
        send(24'h123456, 1'b0);
        send(24'h654321, 1'b1);
        capture(lw, rw, ur, ce);
        checks++;
        if (lw !== 32'h091A_2B00 || rw !== 32'h32A1_9080) begin
            errors++;
            $display("FAIL ferr_pair: L %h R %h, required 091a2b00 32a19080", lw, rw);
        end
        checks++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL ferr_count: %0d pulses, required 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_boundary_right;
        logic [31:0] lw, rw;
        int ur, ce;
        wait_cnt(9'd10);
        send(24'h0F0F0F, 1'b0);
        wait_cnt(9'd511);
        s_data  = 24'hF0F0F0;
        s_last  = 1'b1;
        s_valid = 1'b1;
        step;
        s_valid = 1'b0;
        checks++;
        if (underrun !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bnd_edge: underrun %b ready %b, required 1 0", underrun, s_ready);
        end
        capture(lw, rw, ur, ce);
        checks++;
        if (lw !== 32'h0 || rw !== 32'h0 || ur !== 1) begin
            errors++;
            $display("FAIL bnd_zero_frame: L %h R %h ur %0d, required 0 0 1", lw, rw, ur);
        end
        capture(lw, rw, ur, ce);
        checks++;
        if (lw !== 32'h0787_8780 || rw !== 32'h7878_7800 || ur !== 0) begin
            errors++;
            $display("FAIL bnd_next_frame: L %h R %h ur %0d, required 07878780 78787800 0",
                     lw, rw, ur);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] lw, rw;
        int ur, ce, fe0;
        wait_cnt(9'd200);
        send(24'h222222, 1'b0);
        wait_cnt(9'd300);
        checks++;
        if (tx_sclk !== 1'b1 || tx_lrck !== 1'b1) begin
            errors++;
            $display("FAIL mrst_pre: sclk %b lrck %b, required 1 1", tx_sclk, tx_lrck);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({tx_sclk, tx_lrck, tx_sdout, underrun, frame_err} !== 5'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mrst_immediate: outs %b ready %b, required 00000 1",
                     {tx_sclk, tx_lrck, tx_sdout, underrun, frame_err}, s_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) step;
        checks++;
        if (tx_sclk !== 1'b0) begin
            errors++;
            $display("FAIL mrst_cnt3: sclk %b, required 0", tx_sclk);
        end
        step;
        checks++;
        if (tx_sclk !== 1'b1) begin
            errors++;
            $display("FAIL mrst_cnt4: sclk %b, required 1", tx_sclk);
        end
        wait_cnt(9'd255);
        checks++;
        if (tx_lrck !== 1'b0) begin
            errors++;
            $display("FAIL mrst_lrck255: lrck %b, required 0", tx_lrck);
        end
        step;
        checks++;
        if (tx_lrck !== 1'b1) begin
            errors++;
            $display("FAIL mrst_lrck256: lrck %b, required 1", tx_lrck);
        end
        fe0 = fe_cnt;
        send(24'h333333, 1'b1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL mrst_partial_discard: frame_err %b, required 1", frame_err);
        end
        capture(lw, rw, ur, ce);
        checks++;
        if (lw !== 32'h0 || rw !== 32'h0 || ur !== 1 || ce !== 0) begin
            errors++;
            $display("FAIL mrst_frame: L %h R %h ur %0d clkerr %0d, required 0 0 1 0",
                     lw, rw, ur, ce);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ur_cnt = 0;
        fe_cnt = 0;
        test_reset;
        test_idle;
        test_pair;
        test_back_to_back;
        test_frame_err;
        test_boundary_right;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_i2s_tx.md
Name: axis_i2s_tx

Overview:
- Standalone I2S transmitter: AXI-Stream slave accepting stereo 24-bit samples, left beat then right beat.
- Serialises each pair onto an I2S line-out (Pmod I2S2 DAC side) with locally generated MCLK, LRCK and SCLK.
- Sits between the filter's master stream and the JA line-out pins, fed from the divided audio clock.
- Isolates the TX path so the RX side can be replaced independently.

Parameters:
- DATA_WIDTH, 24: sample width. Must be ≤ 2**SLOT_LOG2 - 1.
- DIV_LOG2, 3: SCLK = axis_clk / 2**DIV_LOG2.
- SLOT_LOG2, 5: 2**SLOT_LOG2 SCLK periods per channel slot (32).

Ports:
- axis_clk, input, 1: single clock. All logic is on its rising edge.
- axis_resetn, input, 1: asynchronous active-low reset.
- s_axis_data, input, DATA_WIDTH: two's-complement sample.
- s_axis_valid, input, 1: sample valid.
- s_axis_ready, output, 1: block can accept a beat.
- s_axis_last, input, 1: 0 = left sample, 1 = right sample.
- tx_mclk, output, 1: axis_clk forwarded unchanged.
- tx_lrck, output, 1: word select. 0 = left slot, 1 = right slot.
- tx_sclk, output, 1: bit clock.
- tx_sdout, output, 1: serial data, MSB first.
- underrun, output, 1: one-cycle pulse when a frame boundary finds no complete pair.
- frame_err, output, 1: one-cycle pulse on a channel-order violation.

Behaviour:
- Free-running counter cnt, width W = DIV_LOG2 + SLOT_LOG2 + 1 (9 bits). Increments each cycle and wraps 511→0.
- Clock outputs are registered:
  - tx_sclk = cnt[DIV_LOG2-1] (cnt[2]).
  - tx_lrck = cnt[W-1] (cnt[8]).
  - Frame = 512 axis_clk cycles. SCLK = 8 cycles: low for cnt[2:0] = 0..3, high for 4..7.
- tx_sdout is updated only on the edge where cnt[2:0] = 7, so it changes together with SCLK falling. The receiver samples on SCLK rising.
- Bit index b = next cnt[7:3]:
  - b = 1..DATA_WIDTH: drive shift-data bit [DATA_WIDTH - b].
  - b = 0 and b > DATA_WIDTH: drive 0. This gives standard I2S with a one-SCLK delay after the LRCK edge.
- Output shift registers sh_l and sh_r: left is serialised while lrck = 0, right while lrck = 1.
- Input holding FSM with registers hold_l and hold_r:
  - WAIT_L: s_axis_ready = 1.
    - Beat with last = 0: hold_l <= data, go to WAIT_R.
    - Beat with last = 1: dropped, frame_err pulse, stay in WAIT_L.
  - WAIT_R: s_axis_ready = 1.
    - Beat with last = 1: hold_r <= data, go to FULL.
    - Beat with last = 0: overwrite hold_l, frame_err pulse, stay in WAIT_R.
  - FULL: s_axis_ready = 0.
- Frame boundary is the edge where cnt = 511:
  - If state (registered, pre-edge value) is FULL: sh_l <= hold_l, sh_r <= hold_r, state <= WAIT_L.
  - Otherwise: sh_l and sh_r are loaded with 0, underrun pulses, and the FSM state and hold registers are unchanged.
- Simultaneous events: a right beat accepted on the boundary edge in WAIT_R moves to FULL. That boundary still counts as an underrun, and the pair is emitted at the next boundary.
- Latency: a pair completed before boundary k is emitted in frame k. Left MSB appears on tx_sdout at cnt = 8, i.e. 8 cycles after the load edge.
- Reset (asynchronous, immediate):
  - cnt = 0; state = WAIT_L; hold and shift registers = 0.
  - tx_sdout = 0, tx_sclk = 0, tx_lrck = 0; underrun = 0, frame_err = 0.
  - s_axis_ready = 1 after release.
  - tx_mclk keeps toggling during reset.
  - Reset mid-frame discards any partial pair and any in-flight frame.
- Full-scale values are passed untouched. No arithmetic is performed on the samples.

Test Plan:
- Reset, then idle: tx_lrck period = 512 cycles, tx_sclk period = 8 cycles, tx_sdout = 0, one underrun pulse every 512 cycles.
- Send L = 0x800001, R = 0x7FFFFE before the first boundary. Expect:
  - Left slot SDOUT bits b1..b24 = 1000 0000 0000 0000 0000 0001.
  - Right slot bits b1..b24 = 0111 1111 1111 1111 1111 1110.
  - Bits b0 and b25..b31 = 0; no underrun.
- Hold valid high continuously: s_axis_ready drops after the right beat, rises the cycle after cnt = 511, and exactly 2 beats are accepted per 512 cycles.
- Send a beat with last = 1 while in WAIT_L, then L = 0x123456, R = 0x654321: frame_err pulses once, the first beat is discarded, and the pair is transmitted correctly.
- Complete the right beat exactly on the cnt = 511 edge: underrun pulses that cycle, the frame is zeros, and the pair appears in the next frame.
- Assert axis_resetn low at cnt = 300 mid-frame: all outputs go to 0 immediately, and the counter restarts from 0 on release.
